// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave oven controller and its cook timer.
package microwave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_COOK   = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  localparam int DEFAULT_TICKS_PER_SEC = 100;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock down to one-second ticks; the count freezes while disabled
// so a paused cook resumes mid-second.
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic clk,
  input  logic sys_reset_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick is only meaningful while enabled, so a disabled wrap cycle is lost.
  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/microwave_cook_timer.sv
// Cook-time countdown: counts loaded seconds while the oven heats with the door
// closed, and returns a one-cycle done strobe to the oven controller.
module microwave_cook_timer
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
  parameter int SEC_W         = 12
) (
  input  logic             clk,
  input  logic             sys_reset_n,
  input  logic             load,
  input  logic [SEC_W-1:0] load_secs,
  input  logic             cancel,
  input  logic             heat,
  input  logic             close,
  output logic             done,
  output logic             magnetron_en,
  output logic             paused,
  output logic [SEC_W-1:0] remaining
);

  state_e           state_q, state_d;
  logic [SEC_W-1:0] rem_q, rem_d;
  logic             done_q, mag_q, paused_q;
  logic             heating, run, clr, tick, load_ok;

  assign heating = heat && close;
  assign load_ok = load && (load_secs != '0);
  assign run     = (state_q == ST_COOK) && heating && !cancel;
  assign clr     = cancel || (state_q == ST_IDLE);

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk        (clk),
    .sys_reset_n(sys_reset_n),
    .en_i       (run),
    .clr_i      (clr),
    .tick_o     (tick)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (cancel) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_ok) begin
            state_d = ST_ARMED;
            rem_d   = load_secs;
          end
        end
        ST_ARMED: begin
          if (heating) begin
            state_d = ST_COOK;
          end else if (load_ok) begin
            rem_d = load_secs;
          end
        end
        ST_COOK: begin
          if (!heating) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            // Guarding with <= 1 keeps the counter from ever wrapping below zero.
            if (rem_q <= SEC_W'(1)) begin
              rem_d   = '0;
              state_d = ST_FINISH;
            end else begin
              rem_d = rem_q - 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (heating) begin
            state_d = ST_COOK;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge.
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      done_q   <= 1'b0;
      mag_q    <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      done_q   <= (state_d == ST_FINISH);
      mag_q    <= (state_d == ST_COOK);
      paused_q <= (state_d == ST_PAUSE);
    end
  end

  assign done         = done_q;
  assign magnetron_en = mag_q;
  assign paused       = paused_q;
  assign remaining    = rem_q;

endmodule

// File: tb/tb_microwave_cook_timer.sv
// Bench for microwave_cook_timer: two instances (4 and 1 ticks/second) share
// stimulus and are each compared with a cycles-remaining reference model.
module tb_microwave_cook_timer;

  localparam int SEC_W = 12;
  localparam int M_IDLE = 0, M_ARMED = 1, M_COOK = 2, M_PAUSE = 3, M_FINISH = 4;

  logic             clk = 1'b0;
  logic             sys_reset_n;
  logic             load, cancel, heat, close;
  logic [SEC_W-1:0] load_secs;
  logic             done_o [2];
  logic             mag_o  [2];
  logic             pau_o  [2];
  logic [SEC_W-1:0] rem_o  [2];

  int checks = 0;
  int failures = 0;
  int tps [2] = '{4, 1};
  int mmode [2];
  int mrc [2];
  int magcnt [2];
  int paucnt [2];
  int donecnt [2];
  logic prev_done [2];

  always #5 clk = ~clk;

  microwave_cook_timer #(.TICKS_PER_SEC(4), .SEC_W(SEC_W)) u_t4 (
    .clk(clk), .sys_reset_n(sys_reset_n), .load(load), .load_secs(load_secs),
    .cancel(cancel), .heat(heat), .close(close), .done(done_o[0]),
    .magnetron_en(mag_o[0]), .paused(pau_o[0]), .remaining(rem_o[0])
  );

  microwave_cook_timer #(.TICKS_PER_SEC(1), .SEC_W(SEC_W)) u_t1 (
    .clk(clk), .sys_reset_n(sys_reset_n), .load(load), .load_secs(load_secs),
    .cancel(cancel), .heat(heat), .close(close), .done(done_o[1]),
    .magnetron_en(mag_o[1]), .paused(pau_o[1]), .remaining(rem_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mmode[i] = M_IDLE;
      mrc[i]   = 0;
      prev_done[i] = 1'b0;
    end
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 2; i++) begin
      magcnt[i] = 0; paucnt[i] = 0; donecnt[i] = 0;
    end
  endtask

  // Model: time left is tracked as cooking cycles; display is the ceiling in seconds.
  task automatic model_edge(input int i);
    bit hc;
    hc = heat && close;
    if (cancel) begin
      mmode[i] = M_IDLE;
      mrc[i]   = 0;
    end else begin
      case (mmode[i])
        M_IDLE:  if (load && load_secs != 0) begin
                   mmode[i] = M_ARMED; mrc[i] = int'(load_secs) * tps[i];
                 end
        M_ARMED: if (hc) mmode[i] = M_COOK;
                 else if (load && load_secs != 0) mrc[i] = int'(load_secs) * tps[i];
        M_COOK:  if (!hc) mmode[i] = M_PAUSE;
                 else begin
                   mrc[i]--;
                   if (mrc[i] == 0) mmode[i] = M_FINISH;
                 end
        M_PAUSE: if (hc) mmode[i] = M_COOK;
        default: mmode[i] = M_IDLE;
      endcase
    end
  endtask

  task automatic check_model(input int i);
    string s;
    s = (i == 0) ? "t4" : "t1";
    chk({s, "_done"},   32'(done_o[i]), 32'(mmode[i] == M_FINISH));
    chk({s, "_mag"},    32'(mag_o[i]),  32'(mmode[i] == M_COOK));
    chk({s, "_paused"}, 32'(pau_o[i]),  32'(mmode[i] == M_PAUSE));
    chk({s, "_rem"},    32'(rem_o[i]),  32'((mrc[i] + tps[i] - 1) / tps[i]));
    chk({s, "_done_twice"}, 32'(prev_done[i] && done_o[i]), 32'(0));
    prev_done[i] = done_o[i];
    if (mag_o[i])  magcnt[i]++;
    if (pau_o[i])  paucnt[i]++;
    if (done_o[i]) donecnt[i]++;
  endtask

  task automatic step(input bit l, input int ls, input bit c, input bit h, input bit cl);
    @(negedge clk);
    load = l; load_secs = SEC_W'(ls); cancel = c; heat = h; close = cl;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    for (int i = 0; i < 2; i++) check_model(i);
  endtask

  initial begin
    int n;
    bit rc, rl, rh, rcl, hc;
    sys_reset_n = 1'b0;
    load = 0; load_secs = '0; cancel = 0; heat = 0; close = 0;
    model_reset();
    clr_cnt();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", 32'(done_o[0]), 0);
    chk("reset_mag", 32'(mag_o[0]), 0);
    chk("reset_rem", 32'(rem_o[0]), 0);
    @(negedge clk);
    sys_reset_n = 1'b1;

    // Load 3, cook to completion
    step(1, 3, 0, 0, 0);
    chk("t1_armed_rem", 32'(rem_o[0]), 3);
    clr_cnt();
    repeat (15) step(0, 0, 0, 1, 1);
    chk("t1_mag_cycles", 32'(magcnt[0]), 12);
    chk("t1_done_pulses", 32'(donecnt[0]), 1);
    step(0, 0, 0, 0, 0);

    // Load 2, cook 5 cycles, open door for 7, resume
    step(1, 2, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    repeat (5) step(0, 0, 0, 1, 1);
    clr_cnt();
    repeat (7) step(0, 0, 0, 1, 0);
    chk("t2_rem_at_pause", 32'(rem_o[0]), 1);
    chk("t2_pause_cycles", 32'(paucnt[0]), 7);
    repeat (3) step(0, 0, 0, 1, 1);
    chk("t2_no_early_done", 32'(done_o[0]), 0);
    step(0, 0, 0, 1, 1);
    chk("t2_done_after_resume", 32'(done_o[0]), 1);
    step(0, 0, 0, 0, 0);

    // Cancel on the final tick
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1, 1);
    step(0, 0, 1, 1, 1);
    chk("t3_cancel_done", 32'(done_o[0]), 0);
    chk("t3_cancel_rem", 32'(rem_o[0]), 0);
    step(0, 0, 0, 1, 1);
    chk("t3_after_done", 32'(done_o[0]), 0);

    // Load rules
    step(1, 0, 0, 0, 0);
    chk("t4_load0_rem", 32'(rem_o[0]), 0);
    step(1, 5, 0, 0, 0);
    step(1, 9, 0, 0, 0);
    chk("t4_reload_rem", 32'(rem_o[0]), 9);
    step(0, 0, 0, 1, 1);
    step(1, 3, 0, 1, 1);
    chk("t4_load_in_cook", 32'(rem_o[0]), 9);
    step(0, 0, 1, 0, 0);

    // Asynchronous reset mid-cook
    step(1, 7, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 1);
    @(posedge clk);
    #3 sys_reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("t5_rst_mag", 32'(mag_o[i]), 0);
      chk("t5_rst_rem", 32'(rem_o[i]), 0);
      chk("t5_rst_done", 32'(done_o[i]), 0);
      chk("t5_rst_paused", 32'(pau_o[i]), 0);
    end
    model_reset();
    @(negedge clk);
    load = 0; cancel = 0; heat = 0; close = 0;
    sys_reset_n = 1'b1;
    step(1, 4, 0, 0, 0);
    chk("t5_load_after_rst", 32'(rem_o[0]), 4);
    step(0, 0, 1, 0, 0);

    // Full-scale load, one tick per second
    step(1, 4095, 0, 0, 0);
    clr_cnt();
    n = 0;
    while (donecnt[1] == 0 && n < 5000) begin
      step(0, 0, 0, 1, 1);
      n++;
    end
    chk("t6_done_seen", 32'(donecnt[1]), 1);
    chk("t6_mag_cycles", 32'(magcnt[1]), 4095);
    chk("t6_rem_final", 32'(rem_o[1]), 0);
    step(0, 0, 1, 0, 0);

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      rc  = ($urandom_range(0, 99) < 2);
      rl  = ($urandom_range(0, 99) < 8);
      hc  = ($urandom_range(0, 99) < 85);
      rh  = hc ? 1'b1 : 1'($urandom_range(0, 1));
      rcl = hc ? 1'b1 : 1'($urandom_range(0, 1));
      step(rl, int'($urandom_range(0, 6)), rc, rh, rcl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/microwave_cook_timer.md
# microwave_cook_timer

Cook-time countdown that sits on the other side of the `microwave` oven controller. It takes a cook duration from the control panel and counts it down only while the controller holds `Heat` with the door closed. It returns the one-cycle `done` strobe that moves the controller out of its heating state. It also drives the magnetron enable and a remaining-seconds value for the display.

## Interface
- `TICKS_PER_SEC`, default 100: clock cycles per counted second; legal range ≥ 1.
- `SEC_W`, default 12: width of the seconds count; maximum load is 2^SEC_W−1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `sys_reset_n`  in  1  reset, asynchronous, active-low.
- `load`  in  1  single-cycle strobe; captures `load_secs`.
- `load_secs`  in  SEC_W  cook duration in seconds.
- `cancel`  in  1  level; aborts and clears the timer.
- `heat`  in  1  the controller's `Heat` output.
- `close`  in  1  the controller's `Close` output (door closed).
- `done`  out  1  one-cycle pulse to the controller's `done` input.
- `magnetron_en`  out  1  high only while counting.
- `paused`  out  1  high while a partially used time is held.
- `remaining`  out  SEC_W  whole seconds left.

## Operation
- States: IDLE, ARMED, COOK, PAUSE, FINISH.
- Input priority each cycle: `cancel` > loss of `heat`/`close` > `load` > tick.
- IDLE:
  - `load` with `load_secs`≠0 → ARMED, `remaining`←`load_secs`, prescaler←0.
  - `load` with 0 is ignored.
- ARMED:
  - `heat && close` → COOK.
  - `load` (nonzero) reloads `remaining`.
  - `cancel` → IDLE.
- COOK:
  - Prescaler counts 0..TICKS_PER_SEC−1 and then wraps to 0. The wrap cycle is a tick.
  - A tick decrements `remaining`.
  - A tick with `remaining`==1 sets `remaining`←0 → FINISH.
  - `!heat || !close` → PAUSE. The prescaler holds its value, and a tick coinciding with the pause is discarded.
  - `load` is ignored.
- PAUSE:
  - `heat && close` → COOK; the prescaler resumes from its held value.
  - `load` is ignored.
  - `cancel` → IDLE.
- FINISH: unconditionally → IDLE next cycle.
- `cancel` in any state → IDLE with `remaining`←0 and prescaler←0. This includes a `cancel` coinciding with a final tick, in which case no `done` is issued.
- Outputs are Moore and registered:
  - `done` = (state==FINISH)
  - `magnetron_en` = (state==COOK)
  - `paused` = (state==PAUSE)
- Width rules: `remaining` never underflows. The prescaler is $clog2(TICKS_PER_SEC) bits, minimum 1. When TICKS_PER_SEC=1, every COOK cycle is a tick.

## Timing
- Reset (async assert, synchronous release):
  - state IDLE, prescaler 0, `remaining`=0
  - `done`=0, `magnetron_en`=0, `paused`=0
- Reset mid-operation discards all progress.
- Latency:
  - From `load` to ARMED: 1 cycle.
  - From first `heat && close` sample to `magnetron_en`=1: 1 cycle.
- A load of N seconds with no pauses gives exactly N·TICKS_PER_SEC cycles with `magnetron_en`=1. `done` is high on the following cycle only.
- Pauses extend the total by exactly the number of cycles spent in PAUSE.
- `done` is never asserted for two consecutive cycles. The controller therefore sees it for one edge and moves from Heat to Close-only.
- `heat` dropping because the controller reacts to `done` has no effect: the timer is already in FINISH/IDLE.

## Structure
- Shared `microwave_pkg`:
  - the state enum typedef (IDLE=0 … FINISH=4, 3-bit encoding)
  - a default `TICKS_PER_SEC` constant
- One sub-module, `tick_prescaler`:
  - inputs: enable, clear
  - output: one-cycle `tick` on wrap
  - holds its count when enable is low
- The FSM and the seconds counter stay in `microwave_cook_timer`.

## Test plan
- TICKS_PER_SEC=4. Load 3, then hold `heat=close=1` → `magnetron_en` high for exactly 12 cycles, `remaining` steps 3→2→1→0, then a single `done` pulse and return to IDLE.
- Load 2, cook 5 cycles, drop `close` for 7 cycles, raise it again → `remaining`=1 at the pause, `paused`=1 for 7 cycles, `done` arrives 3 cycles after resume plus 1.
- Assert `cancel` on the same cycle as the final tick → no `done`, `remaining`=0, IDLE.
- Load 0 in IDLE → stays IDLE. Load 5 then load 9 in ARMED → `remaining`=9. A `load` during COOK → ignored.
- Assert `sys_reset_n` low asynchronously mid-COOK, between clock edges → all outputs 0 immediately; after release the block accepts a new `load`.
- TICKS_PER_SEC=1. Load 2^SEC_W−1 → `done` exactly 4095 cycles after COOK entry with SEC_W=12; no underflow.
